// File: rtl/tx_serial_medida_pkg.sv
// Shared definitions for the DHT11 measurement serial link.
// State codes and parity modes are common to transmitter and receiver.
package tx_serial_medida_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'h0,
    ST_START = 4'h1,
    ST_DATA  = 4'h2,
    ST_PAR   = 4'h3,
    ST_STOP  = 4'h4,
    ST_DONE  = 4'h5
  } estado_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic logic bit_paridade(
    input logic xor_red,
    input int   modo
  );
    return (modo == PAR_ODD) ? ~xor_red : xor_red;
  endfunction

  // Counter width that still works for a modulus of 1.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_serial_medida_contador_m.sv
// Modulo-M counter with terminal-count flag.
// Async clear kept for the common counter shape; callers tie it low.
module contador_m #(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic clock,
  input  logic zera_as,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] q;

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      q <= '0;
    end else if (zera_s) begin
      q <= '0;
    end else if (conta) begin
      if (q == N'(M - 1)) begin
        q <= '0;
      end else begin
        q <= q + 1'b1;
      end
    end
  end

  assign fim = conta && (q == N'(M - 1));

endmodule

// File: rtl/tx_serial_medida.sv
// UART-style transmitter for one DHT11 word {umidade, temperatura}:
// start bit, LSB-first data, optional parity, one stop bit.
module tx_serial_medida
  import tx_serial_medida_pkg::*;
#(
  parameter int BAUD_RATE = 9600,
  parameter int CLOCK_HZ  = 50_000_000,
  parameter int N_BITS    = 32,
  parameter int PARITY    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              partida,
  input  logic [N_BITS-1:0] dados,
  output logic              txd,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int CW = largura(CLKS_PER_BIT);
  localparam int BW = largura(N_BITS);

  estado_t           estado;
  logic [N_BITS-1:0] shift;
  logic [BW-1:0]     bidx;
  logic              par_bit;
  logic              tick;
  logic              zera;

  // Holding the baud counter clear in IDLE restarts it on every frame.
  assign zera = reset | (estado == ST_IDLE);

  contador_m #(
    .M(CLKS_PER_BIT),
    .N(CW)
  ) u_baud (
    .clock  (clock),
    .zera_as(1'b0),
    .zera_s (zera),
    .conta  (1'b1),
    .fim    (tick)
  );

  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= ST_IDLE;
      txd     <= 1'b1;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
      shift   <= '0;
      bidx    <= '0;
      par_bit <= 1'b0;
    end else begin
      pronto <= 1'b0;
      unique case (estado)
        ST_IDLE: begin
          txd     <= 1'b1;
          ocupado <= 1'b0;
          if (partida) begin
            shift   <= dados;
            par_bit <= bit_paridade(^dados, PARITY);
            bidx    <= '0;
            txd     <= 1'b0;
            ocupado <= 1'b1;
            estado  <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            txd    <= shift[0];
            shift  <= shift >> 1;
            estado <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bidx == BW'(N_BITS - 1)) begin
              if (PARITY != PAR_NONE) begin
                txd    <= par_bit;
                estado <= ST_PAR;
              end else begin
                txd    <= 1'b1;
                estado <= ST_STOP;
              end
            end else begin
              bidx  <= bidx + 1'b1;
              txd   <= shift[0];
              shift <= shift >> 1;
            end
          end
        end
        ST_PAR: begin
          if (tick) begin
            txd    <= 1'b1;
            estado <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            ocupado <= 1'b0;
            pronto  <= 1'b1;
            estado  <= ST_DONE;
          end
        end
        ST_DONE: begin
          estado <= ST_IDLE;
        end
        default: begin
          estado <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_serial_medida.sv
// Bench for tx_serial_medida: three parity modes at 16 clocks/bit
// against a frame-level model, plus a short run at default rates.
module tb_tx_serial_medida;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        partida = 1'b0;
  logic [31:0] dados = '0;
  logic        partida_d = 1'b0;
  logic [31:0] dados_d = '0;

  logic        txd_v[3];
  logic        ocu_v[3];
  logic        pr_v[3];
  logic [3:0]  st_v[3];
  logic        txd_d, ocu_d, pr_d;
  logic [3:0]  st_d;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tx_serial_medida #(.BAUD_RATE(1), .CLOCK_HZ(16), .N_BITS(32), .PARITY(0)) u_p0 (
    .clock(clk), .reset(rst), .partida(partida), .dados(dados),
    .txd(txd_v[0]), .ocupado(ocu_v[0]), .pronto(pr_v[0]), .db_estado(st_v[0]));
  tx_serial_medida #(.BAUD_RATE(1), .CLOCK_HZ(16), .N_BITS(32), .PARITY(1)) u_p1 (
    .clock(clk), .reset(rst), .partida(partida), .dados(dados),
    .txd(txd_v[1]), .ocupado(ocu_v[1]), .pronto(pr_v[1]), .db_estado(st_v[1]));
  tx_serial_medida #(.BAUD_RATE(1), .CLOCK_HZ(16), .N_BITS(32), .PARITY(2)) u_p2 (
    .clock(clk), .reset(rst), .partida(partida), .dados(dados),
    .txd(txd_v[2]), .ocupado(ocu_v[2]), .pronto(pr_v[2]), .db_estado(st_v[2]));
  tx_serial_medida u_def (
    .clock(clk), .reset(rst), .partida(partida_d), .dados(dados_d),
    .txd(txd_d), .ocupado(ocu_d), .pronto(pr_d), .db_estado(st_d));

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [dut %0d] got %0h want %0h at cyc %0d",
               nm, idx, act, exp, cyc);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the first start-bit cycle (t=0).
  task automatic pulse();
    partida = 1'b1;
    adv(1);
    partida = 1'b0;
  endtask

  // Frame model: cycle t of a frame maps to line bit t/CPB.
  function automatic int flen(input int m);
    return ((m == 0) ? 34 : 35) * CPB;
  endfunction

  function automatic logic exp_bit(input logic [31:0] w, input int m, input int b);
    if (b == 0) return 1'b0;
    if (b <= 32) return w[b-1];
    if (b == 33 && m != 0) return (m == 1) ? ^w : ~^w;
    return 1'b1;
  endfunction

  logic        busy_m[3] = '{default: 1'b0};
  int          t_m[3] = '{default: 0};
  logic [31:0] w_m[3];
  int          pr_cnt[3] = '{default: 0};
  logic        chk_on = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        busy_m[i] <= 1'b0;
      end else if (!busy_m[i]) begin
        if (partida) begin
          busy_m[i] <= 1'b1;
          t_m[i]    <= 0;
          w_m[i]    <= dados;
        end
      end else if (t_m[i] == flen(i)) begin
        busy_m[i] <= 1'b0;
      end else begin
        t_m[i] <= t_m[i] + 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int i = 0; i < 3; i++) begin
          logic et, eo, ep;
          logic [3:0] es;
          int b;
          if (!busy_m[i]) begin
            et = 1'b1; eo = 1'b0; ep = 1'b0; es = 4'd0;
          end else if (t_m[i] == flen(i)) begin
            et = 1'b1; eo = 1'b0; ep = 1'b1; es = 4'd5;
          end else begin
            b  = t_m[i] / CPB;
            et = exp_bit(w_m[i], i, b);
            eo = 1'b1;
            ep = 1'b0;
            if (b == 0) es = 4'd1;
            else if (b <= 32) es = 4'd2;
            else if (b == 33 && i != 0) es = 4'd3;
            else es = 4'd4;
          end
          chk("txd", i, txd_v[i], et);
          chk("ocupado", i, ocu_v[i], eo);
          chk("pronto", i, pr_v[i], ep);
          chk("db_estado", i, st_v[i], es);
          if (pr_v[i] === 1'b1) pr_cnt[i]++;
        end
      end
    end
  end

  task automatic rx_frame(output logic [31:0] w, output logic p,
                          output logic s, output int c);
    int n;
    n = 0; w = '0; p = 1'b0; s = 1'b0; c = 0;
    do begin
      adv(1);
      n++;
    end while (txd_v[1] !== 1'b0 && n < 2000);
    if (n >= 2000) begin
      chk("rx start timeout", 1, txd_v[1], 0);
      return;
    end
    c = cyc;
    adv(8);
    chk("rx start bit", 1, txd_v[1], 0);
    for (int b = 0; b < 32; b++) begin
      adv(16);
      w[b] = txd_v[1];
    end
    adv(16);
    p = txd_v[1];
    adv(16);
    s = txd_v[1];
  endtask

  logic seq8[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  int   base[3];
  logic [31:0] w1, w2;
  logic p1, p2, s1, s2;
  int   c1, c2;

  initial begin
    adv(3);
    chk_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("reset txd", i, txd_v[i], 1);
      chk("reset ocupado", i, ocu_v[i], 0);
      chk("reset pronto", i, pr_v[i], 0);
      chk("reset estado", i, st_v[i], 0);
    end
    chk("reset txd", 9, txd_d, 1);
    chk("reset estado", 9, st_d, 0);
    rst = 1'b0;

    // default rates: 5208 clocks per bit
    dados_d = 32'h0032_0019;
    partida_d = 1'b1;
    adv(1);
    partida_d = 1'b0;
    adv(2604);
    chk("def start txd", 9, txd_d, 0);
    chk("def start ocupado", 9, ocu_d, 1);
    chk("def start estado", 9, st_d, 1);
    adv(5208);
    chk("def bit0", 9, txd_d, 1);
    chk("def bit0 estado", 9, st_d, 2);
    adv(5208);
    chk("def bit1", 9, txd_d, 0);
    rst = 1'b1;
    adv(1);
    chk("def reset txd", 9, txd_d, 1);
    chk("def reset ocupado", 9, ocu_d, 0);
    rst = 1'b0;
    adv(4);

    // 50 %, 25 C
    dados = 32'h0032_0019;
    pulse();
    adv(8);
    chk("start bit", 1, txd_v[1], 0);
    for (int b = 0; b < 8; b++) begin
      adv(16);
      chk("data bit lit", 1, txd_v[1], seq8[b]);
    end
    adv(400);
    chk("even parity lit", 1, txd_v[1], 0);
    chk("odd parity lit", 2, txd_v[2], 1);
    chk("no-parity stop lit", 0, txd_v[0], 1);
    chk("par estado lit", 1, st_v[1], 3);
    adv(8);
    chk("pronto 544 lit", 0, pr_v[0], 1);
    chk("busy at 544 lit", 1, ocu_v[1], 1);
    adv(16);
    chk("pronto 560 lit", 1, pr_v[1], 1);
    chk("pronto 560 lit", 2, pr_v[2], 1);
    chk("done estado lit", 1, st_v[1], 5);
    adv(1);
    chk("pronto pulse end", 1, pr_v[1], 0);
    adv(10);

    dados = 32'h0000_0001;
    pulse();
    adv(536);
    chk("even parity of 1", 1, txd_v[1], 1);
    chk("odd parity of 1", 2, txd_v[2], 0);
    adv(8);
    chk("34-bit frame pronto", 0, pr_v[0], 1);
    adv(30);

    // partida while busy
    for (int i = 0; i < 3; i++) base[i] = pr_cnt[i];
    dados = 32'h1234_5678;
    pulse();
    adv(100);
    dados = 32'hFFFF_FFFF;
    partida = 1'b1;
    adv(1);
    partida = 1'b0;
    adv(51);
    chk("latched data bit8", 1, txd_v[1], 0);
    adv(448);
    for (int i = 0; i < 3; i++) begin
      chk("single pronto", i, pr_cnt[i] - base[i], 1);
      chk("idle after frame", i, ocu_v[i], 0);
    end

    // reset during data bit 10
    dados = 32'h0F0F_00FF;
    pulse();
    adv(184);
    rst = 1'b1;
    adv(1);
    chk("mid reset txd", 1, txd_v[1], 1);
    chk("mid reset ocupado", 1, ocu_v[1], 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) base[i] = pr_cnt[i];
    adv(40);
    for (int i = 0; i < 3; i++)
      chk("no pronto after reset", i, pr_cnt[i] - base[i], 0);
    dados = 32'hA5A5_5A5A;
    pulse();
    adv(536);
    chk("A5 even parity", 1, txd_v[1], 0);
    chk("A5 odd parity", 2, txd_v[2], 1);
    adv(24);
    chk("A5 pronto", 1, pr_v[1], 1);
    adv(10);

    // loopback with partida held high
    dados = 32'h0032_0019;
    partida = 1'b1;
    rx_frame(w1, p1, s1, c1);
    dados = 32'h8000_0001;
    rx_frame(w2, p2, s2, c2);
    partida = 1'b0;
    chk("rx word 1", 1, w1, 32'h0032_0019);
    chk("rx parity 1", 1, ^{w1, p1}, 0);
    chk("rx stop 1", 1, s1, 1);
    chk("rx word 2", 1, w2, 32'h8000_0001);
    chk("rx parity 2", 1, ^{w2, p2}, 0);
    chk("rx stop 2", 1, s2, 1);
    chk("inter-frame gap", 1, c2 - c1 - 560, 2);
    adv(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
